// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry circular write buffer with byte-wise load forwarding.
// Optional same-word store merging when STBUF_COALESCE_EN is defined.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W/8-1:0] st_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic [DATA_W-1:0]   ld_data,
  output logic [DATA_W/8-1:0] ld_mask,
  output logic                ld_conflict,
  input  logic                drain,
  output logic                empty,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  output logic [DATA_W/8-1:0] mem_we
);

  localparam int NB = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] e_addr [DEPTH];
  logic [DATA_W-1:0] e_data [DEPTH];
  logic [NB-1:0]     e_we   [DEPTH];
  logic [DEPTH-1:0]  e_vld;
  logic [DEPTH-1:0]  vld_nxt;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] last;
  logic [CW-1:0] count;

  logic          pop;
  logic          st_acc;
  logic          push;
  logic          merge;
  logic          coalesce_hit;

  logic [DATA_W-1:0] fwd_data;
  logic [NB-1:0]     fwd_mask;

  assign last    = tail - PW'(1);
  assign empty   = (count == '0);
  assign mem_req = !empty;
  assign pop     = mem_req && mem_gnt;

`ifdef STBUF_COALESCE_EN
  assign coalesce_hit = !empty
                     && (st_addr == e_addr[last])
                     && !((count == CW'(1)) && mem_gnt);
`else
  assign coalesce_hit = 1'b0;
`endif

  assign st_ready = ((count < CW'(DEPTH)) || coalesce_hit)
                 && !(drain && !empty);

  assign st_acc = st_valid && st_ready && (|st_we);
  assign push   = st_acc && !coalesce_hit;
  assign merge  = st_acc && coalesce_hit;

  assign mem_addr = empty ? '0 : e_addr[head];
  assign mem_din  = empty ? '0 : e_data[head];
  assign mem_we   = empty ? '0 : e_we[head];

  // Entry payload: allocate at tail, or merge lanes into youngest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_we[i]   <= '0;
      end
    end else begin
      if (push) begin
        e_addr[tail] <= st_addr;
        e_data[tail] <= st_data;
        e_we[tail]   <= st_we;
      end
      if (merge) begin
        for (int b = 0; b < NB; b++) begin
          if (st_we[b]) begin
            e_data[last][8*b +: 8] <= st_data[8*b +: 8];
          end
        end
        e_we[last] <= e_we[last] | st_we;
      end
    end
  end

  // Next valid bits: popped head clears, allocated tail sets.
  always_comb begin
    vld_nxt = e_vld;
    if (pop) begin
      vld_nxt[head] = 1'b0;
    end
    if (push) begin
      vld_nxt[tail] = 1'b1;
    end
  end

  // Valid bits register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld <= '0;
    end else begin
      e_vld <= vld_nxt;
    end
  end

  // Head/tail pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push) begin
        tail <= tail + PW'(1);
      end
    end
  end

  // Occupancy: unchanged on simultaneous push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

  // Forwarding scan oldest to youngest so the youngest match wins per lane.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = head;
    fwd_data = '0;
    fwd_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (e_vld[idx] && (e_addr[idx] == ld_addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (e_we[idx][b]) begin
            fwd_data[8*b +: 8] = e_data[idx][8*b +: 8];
            fwd_mask[b]        = 1'b1;
          end
        end
      end
    end
  end

  assign ld_data     = fwd_data;
  assign ld_mask     = fwd_mask;
  assign ld_conflict = (|fwd_mask) && !(&fwd_mask);

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table vectors, directed corner sequences and a
// randomized run against a queue-based reference of the store buffer.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int NB     = 4;

`ifdef STBUF_COALESCE_EN
  localparam bit CO = 1'b1;
`else
  localparam bit CO = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [NB-1:0]     st_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [NB-1:0]     ld_mask;
  logic              ld_conflict;
  logic              drain;
  logic              empty;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [NB-1:0]     mem_we;

  store_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_we      (st_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_mask    (ld_mask),
    .ld_conflict(ld_conflict),
    .drain      (drain),
    .empty      (empty),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [NB-1:0]     we;
  } ent_t;

  typedef struct {
    logic              sv;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [NB-1:0]     we;
    logic              g;
    logic              dr;
    logic [ADDR_W-1:0] la;
    logic              rdy;
    logic              req;
    logic [NB-1:0]     mwe;
    logic [DATA_W-1:0] ldd;
    logic [NB-1:0]     lm;
    logic              cf;
  } vec_t;

  ent_t q[$];
  vec_t tbl[12];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(
    input logic sv, input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] d, input logic [NB-1:0] we,
    input logic g, input logic dr, input logic [ADDR_W-1:0] la,
    input logic rdy, input logic req, input logic [NB-1:0] mwe,
    input logic [DATA_W-1:0] ldd, input logic [NB-1:0] lm,
    input logic cf);
    vec_t v;
    v.sv = sv; v.a = a; v.d = d; v.we = we; v.g = g; v.dr = dr;
    v.la = la; v.rdy = rdy; v.req = req; v.mwe = mwe;
    v.ldd = ldd; v.lm = lm; v.cf = cf;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Merge applies to the newest queued store, unless it is the lone
  // entry leaving this cycle.
  function automatic bit m_hit();
`ifdef STBUF_COALESCE_EN
    return (q.size() > 0) && (st_addr == q[$].a)
        && !((q.size() == 1) && mem_gnt);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return ((q.size() < DEPTH) || m_hit()) && !(drain && q.size() != 0);
  endfunction

  task automatic m_fwd(input logic [ADDR_W-1:0] la,
                       output logic [DATA_W-1:0] d, output logic [NB-1:0] m);
    d = '0;
    m = '0;
    for (int b = 0; b < NB; b++) begin
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (!m[b] && q[j].a == la && q[j].we[b]) begin
          d[8*b +: 8] = q[j].d[8*b +: 8];
          m[b] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_check();
    logic [DATA_W-1:0] d;
    logic [NB-1:0]     m;
    m_fwd(ld_addr, d, m);
    check("st_ready", st_ready, m_ready());
    check("empty", empty, q.size() == 0);
    check("mem_req", mem_req, q.size() != 0);
    check("mem_addr", mem_addr, q.size() ? q[0].a : '0);
    check("mem_din", mem_din, q.size() ? q[0].d : '0);
    check("mem_we", mem_we, q.size() ? q[0].we : '0);
    check("ld_data", ld_data, d);
    check("ld_mask", ld_mask, m);
    check("ld_conflict", ld_conflict, (m != 0) && (m != 4'hF));
  endtask

  task automatic set(input logic sv, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic [NB-1:0] we,
                     input logic g, input logic dr,
                     input logic [ADDR_W-1:0] la);
    @(negedge clk);
    st_valid = sv; st_addr = a; st_data = d; st_we = we;
    mem_gnt = g; drain = dr; ld_addr = la;
    #1;
    model_check();
  endtask

  task automatic tick();
    bit   acc;
    bit   hit;
    bit   pp;
    ent_t e;
    @(posedge clk);
    if (rst_n) begin
      acc = st_valid && m_ready() && (st_we != 0);
      hit = m_hit();
      pp  = mem_gnt && (q.size() != 0);
      if (acc && hit) begin
        e = q[q.size()-1];
        for (int b = 0; b < NB; b++)
          if (st_we[b]) e.d[8*b +: 8] = st_data[8*b +: 8];
        e.we = e.we | st_we;
        q[q.size()-1] = e;
      end else if (acc) begin
        e.a = st_addr; e.d = st_data; e.we = st_we;
        q.push_back(e);
      end
      if (pp) void'(q.pop_front());
    end
  endtask

  task automatic cyc(input logic sv, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic [NB-1:0] we,
                     input logic g, input logic dr,
                     input logic [ADDR_W-1:0] la);
    set(sv, a, d, we, g, dr, la);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 5, 32'hAABBCCDD, 4'hF, 0, 0, 5,
                 1, 0, 4'h0, 32'h0, 4'h0, 0);
    tbl[1]  = mk(1, 5, 32'h00001100, 4'h2, 0, 0, 5,
                 1, 1, 4'hF, 32'hAABBCCDD, 4'hF, 0);
    tbl[2]  = mk(0, 0, 32'h0, 4'h0, 0, 0, 5,
                 1, 1, 4'hF, 32'hAABB11DD, 4'hF, 0);
    tbl[3]  = mk(0, 0, 32'h0, 4'h0, 0, 0, 6,
                 1, 1, 4'hF, 32'h0, 4'h0, 0);
    tbl[4]  = mk(0, 0, 32'h0, 4'h0, 1, 0, 5,
                 1, 1, 4'hF, 32'hAABB11DD, 4'hF, 0);
    tbl[5]  = mk(0, 0, 32'h0, 4'h0, 1, 0, 5,
                 1, !CO, CO ? 4'h0 : 4'h2,
                 CO ? 32'h0 : 32'h00001100, CO ? 4'h0 : 4'h2, !CO);
    tbl[6]  = mk(1, 3, 32'h000000EE, 4'h1, 0, 0, 3,
                 1, 0, 4'h0, 32'h0, 4'h0, 0);
    tbl[7]  = mk(0, 0, 32'h0, 4'h0, 0, 0, 3,
                 1, 1, 4'h1, 32'h000000EE, 4'h1, 1);
    tbl[8]  = mk(1, 3, 32'h12345678, 4'h0, 0, 0, 3,
                 1, 1, 4'h1, 32'h000000EE, 4'h1, 1);
    tbl[9]  = mk(0, 0, 32'h0, 4'h0, 1, 0, 3,
                 1, 1, 4'h1, 32'h000000EE, 4'h1, 1);
    tbl[10] = mk(0, 0, 32'h0, 4'h0, 1, 0, 3,
                 1, 0, 4'h0, 32'h0, 4'h0, 0);
    tbl[11] = mk(0, 0, 32'h0, 4'h0, 0, 1, 3,
                 1, 0, 4'h0, 32'h0, 4'h0, 0);

    rst_n = 1'b0;
    st_valid = 0; st_addr = '0; st_data = '0; st_we = '0;
    mem_gnt = 0; drain = 0; ld_addr = '0;
    #3;
    model_check();
    check("rst st_ready", st_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 12; i++) begin
      set(tbl[i].sv, tbl[i].a, tbl[i].d, tbl[i].we,
          tbl[i].g, tbl[i].dr, tbl[i].la);
      check($sformatf("v%0d rdy", i), st_ready, tbl[i].rdy);
      check($sformatf("v%0d req", i), mem_req, tbl[i].req);
      check($sformatf("v%0d mwe", i), mem_we, tbl[i].mwe);
      check($sformatf("v%0d ldd", i), ld_data, tbl[i].ldd);
      check($sformatf("v%0d lm", i), ld_mask, tbl[i].lm);
      check($sformatf("v%0d cf", i), ld_conflict, tbl[i].cf);
      tick();
    end

    // fill to full, no bypass on pop, ordered drain with wrap
    for (int i = 0; i < DEPTH; i++) begin
      set(1, 14'(i), 32'h11111111 * (i + 1), 4'hF, 0, 0, 0);
      check("fill rdy", st_ready, 1);
      tick();
    end
    set(1, 4, 32'hDEADBEEF, 4'hF, 1, 0, 0);
    check("full rdy", st_ready, 0);
    check("drain0 addr", mem_addr, 0);
    tick();
    for (int i = 1; i < DEPTH; i++) begin
      set(0, 0, 0, 0, 1, 0, 0);
      check("drain addr", mem_addr, i);
      check("drain din", mem_din, 32'h11111111 * (i + 1));
      tick();
    end
    set(0, 0, 0, 0, 0, 0, 0);
    check("drained empty", empty, 1);
    tick();
    cyc(1, 12, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    set(0, 0, 0, 0, 1, 0, 12);
    check("wrap addr", mem_addr, 12);
    check("wrap din", mem_din, 32'hCAFEF00D);
    tick();

    // asynchronous reset with three entries buffered
    cyc(1, 20, 32'h20202020, 4'hF, 0, 0, 20);
    cyc(1, 21, 32'h21212121, 4'hF, 0, 0, 20);
    cyc(1, 22, 32'h22222222, 4'hF, 0, 0, 20);
    set(0, 0, 0, 0, 0, 0, 20);
    check("pre-rst req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("arst empty", empty, 1);
    check("arst req", mem_req, 0);
    check("arst mem_we", mem_we, 0);
    check("arst ld_mask", ld_mask, 0);
    check("arst rdy", st_ready, 1);
    q.delete();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set(0, 0, 0, 0, 1, 0, 20);
      check("post-rst req", mem_req, 0);
      tick();
    end

    // fence with two entries buffered
    cyc(1, 40, 32'h40404040, 4'hF, 0, 0, 0);
    cyc(1, 41, 32'h41414141, 4'hF, 0, 0, 0);
    set(1, 42, 32'h42424242, 4'hF, 0, 1, 0);
    check("fence rdy0", st_ready, 0);
    tick();
    set(1, 42, 32'h42424242, 4'hF, 1, 1, 0);
    check("fence rdy1", st_ready, 0);
    tick();
    set(1, 42, 32'h42424242, 4'hF, 1, 1, 0);
    check("fence rdy2", st_ready, 0);
    tick();
    set(1, 42, 32'h42424242, 4'hF, 0, 1, 0);
    check("fence empty", empty, 1);
    check("fence rdy3", st_ready, 1);
    tick();
    cyc(0, 0, 0, 0, 1, 0, 0);

    // merge into youngest while full
    cyc(1, 30, 32'h30303030, 4'hF, 0, 0, 0);
    cyc(1, 31, 32'h31313131, 4'hF, 0, 0, 0);
    cyc(1, 32, 32'h32323232, 4'hF, 0, 0, 0);
    cyc(1, 9, 32'h0000BBAA, 4'h3, 0, 0, 0);
    set(1, 9, 32'hDDCC0000, 4'hC, 0, 0, 9);
    check("co rdy", st_ready, CO);
    tick();
    set(1, 50, 32'h50505050, 4'hF, 0, 0, 9);
    check("co full", st_ready, 0);
    check("co ld_mask", ld_mask, CO ? 4'hF : 4'h3);
    check("co ld_data", ld_data, CO ? 32'hDDCCBBAA : 32'h0000BBAA);
    tick();
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    set(0, 0, 0, 0, 0, 0, 0);
    check("co empty", empty, 1);
    tick();

    // randomized run against the queue model
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 1) != 0, 14'($urandom_range(0, 3)),
          $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
          14'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Parametrised write buffer between the execute/memory pipeline and the synchronous data memory. Stores retire into a DEPTH-entry circular FIFO in one cycle and drain to dmem whenever the arbiter grants the port. Loads are served byte-wise, youngest entry first, from buffered stores. An optional mode merges back-to-back stores to the same word.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_W, 14: word-address width (dmem addr[15:2]).
- DATA_W, 32: data width; byte lanes NB = DATA_W/8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request from the mem stage (packed data, byte mask).
- st_ready  out  1  store accepted at this edge when st_valid && st_ready.
- st_addr  in  ADDR_W  store word address.
- st_data  in  DATA_W  lane-aligned store data.
- st_we  in  NB  byte write enables.
- ld_addr  in  ADDR_W  load word address; lookup is combinational.
- ld_data  out  DATA_W  forwarded bytes; 0 in lanes not forwarded.
- ld_mask  out  NB  lanes supplied by the buffer.
- ld_conflict  out  1  ld_mask is neither 0 nor all ones; the pipeline must stall the load.
- drain  in  1  fence request.
- empty  out  1  no valid entries.
- mem_req  out  1  head entry is valid and waiting to be written.
- mem_gnt  in  1  dmem port granted this cycle; head is written and popped at this edge.
- mem_addr  out  ADDR_W  head address; 0 when empty.
- mem_din  out  DATA_W  head data; 0 when empty.
- mem_we  out  NB  head byte mask; 0 when empty.

## Operation
- State: entry array {addr, data, we}, head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
- Enqueue: on st_valid && st_ready && |st_we, the entry is written at tail, then tail increments and count increments.
- A store with st_we==0 is accepted and discarded.
- st_ready = (count < DEPTH || coalesce_hit) && !(drain && !empty).
  - When full, st_ready is 0 even if the head pops in the same cycle. There is no full-bypass.
- Dequeue: mem_req = (count != 0). On mem_gnt && mem_req, head increments and count decrements.
  - mem_gnt while empty is ignored.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Forwarding, per lane b: select the youngest valid entry (tail-1 back to head) with addr == ld_addr and we[b] set. That entry drives ld_data lane b and ld_mask[b] = 1.
  - The head being popped this cycle still forwards.
  - A store being enqueued this cycle is not visible to loads until the next cycle.
- Fence: while drain && !empty, stores are back-pressured. The fence is complete when empty = 1.
- Reset (rst_n low, asynchronous): count, head and tail go to 0 and all valid bits clear. Resulting outputs:
  - st_ready = 1, empty = 1, mem_req = 0.
  - mem_addr, mem_din, mem_we, ld_data, ld_mask and ld_conflict are all 0.
  - Reset mid-drain discards all buffered stores.

## Timing
- Store to mem_req: 1 cycle. An enqueue at edge N gives mem_req high after edge N.
- Head write: dmem samples mem_addr/mem_din/mem_we at the same edge that mem_gnt pops the head.
- Forwarding outputs (ld_data, ld_mask, ld_conflict) are purely combinational from ld_addr and registered state.
- Throughput: 1 store in and 1 store out per cycle.
- Worst-case drain from full: DEPTH granted cycles.

## Configuration
- STBUF_COALESCE_EN defined: coalesce_hit is high when all of the following hold:
  - count > 0;
  - st_addr equals the youngest entry's addr;
  - the youngest entry is not the head being popped this cycle (count==1 && mem_gnt).
- On a coalesce hit, the store merges into the youngest entry. Lanes with st_we set overwrite data, we |= st_we, and count and tail are unchanged. This is accepted even when full.
- STBUF_COALESCE_EN undefined: coalesce_hit = 0. Every store with nonzero mask allocates a new entry.

## Test plan
- Reset: hold rst_n low mid-operation with 3 entries buffered. Required: empty=1, mem_req=0, mem_we=0 immediately (asynchronous), and no stale writes after release.
- Fill: with mem_gnt=0, enqueue DEPTH stores to addrs 0..3. Required: st_ready=0 on the 5th store. Then grant one pop per cycle: writes appear in order 0,1,2,3, the pointers wrap, and empty=1 after the 4th grant.
- Forwarding: store 0xAABBCCDD we=1111 to addr 5, then 0x00001100 we=0010 to addr 5, then load addr 5. Required: ld_data=0xAABB11DD, ld_mask=1111, ld_conflict=0. Load addr 6: ld_mask=0.
- Partial hit: buffer a single we=0001 store and load its addr. Required: ld_mask=0001, ld_conflict=1.
- Fence: assert drain with 2 entries and st_valid high. Required: st_ready=0 until the second grant, and empty=1 the cycle after that grant.
- Coalesce (STBUF_COALESCE_EN): two consecutive stores to addr 9 (we=0011 then 1100) while full. Required: the second store is accepted, count stays 4, and the youngest entry has we=1111. With the macro undefined, the second store stalls.
